// File: rtl/fft_frame_controller.sv
// Frame sequencer for the FFT sample memory: fills one N-sample frame (zero-padding
// a short final frame), starts the engine, lends it the address port until done.
module fft_frame_controller #(
    parameter int N      = 100,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] fft_addr,
    output logic              fft_start,
    input  logic              fft_done,
    output logic [CNT_W-1:0]  frame_count,
    output logic [2:0]        state_o,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PAD     = 3'd2,
        S_START   = 3'd3,
        S_COMPUTE = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_eof_seen;
    logic [CNT_W-1:0]  r_frame_count;

    logic              w_accept;
    logic              w_last_addr;

    assign w_last_addr = (r_wptr == LAST_ADDR);
    assign fft_start   = (r_state == S_START);
    assign halted      = (r_state == S_HALT);
    assign state_o     = r_state;
    assign frame_count = r_frame_count;

    // The memory port is steered combinationally so a sample is written in the
    // same cycle it is accepted, and the engine's address passes straight through.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        in_ready  = (r_state == S_LOAD);
        w_accept  = in_ready & in_valid;
        mem_we    = w_accept | (r_state == S_PAD);
        mem_wdata = w_accept ? in_data : '0;
        mem_addr  = '0;
        case (r_state)
            S_LOAD, S_PAD: mem_addr = r_wptr;
            S_COMPUTE:     mem_addr = fft_addr;
            default:       mem_addr = '0;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wptr        <= '0;
            r_eof_seen    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_LOAD;

                S_LOAD: begin
                    if (in_valid) begin
                        // Wrapping the pointer here keeps it within 0..N-1 at all times.
                        r_wptr <= w_last_addr ? '0 : r_wptr + 1'b1;
                        if (in_last) r_eof_seen <= 1'b1;
                        if (w_last_addr)  r_state <= S_START;
                        else if (in_last) r_state <= S_PAD;
                    end else if (in_last) begin
                        if (r_wptr == '0) begin
                            r_state <= S_HALT;
                        end else begin
                            r_eof_seen <= 1'b1;
                            r_state    <= S_PAD;
                        end
                    end
                end

                S_PAD: begin
                    r_wptr <= w_last_addr ? '0 : r_wptr + 1'b1;
                    if (w_last_addr) r_state <= S_START;
                end

                S_START: begin
                    r_wptr  <= '0;
                    r_state <= S_COMPUTE;
                end

                S_COMPUTE: begin
                    if (fft_done) begin
                        r_frame_count <= r_frame_count + 1'b1;
                        r_state       <= r_eof_seen ? S_HALT : S_LOAD;
                    end
                end

                S_HALT: r_state <= S_HALT;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_controller.sv
// Scoreboard bench: an N=4 instance for frame/pad/halt behaviour and an N=100
// instance for mid-frame reset; monitors pop expected writes and start pulses.
module tb_fft_frame_controller;

    localparam int AW = 7;
    localparam int DW = 64;
    localparam int CW = 16;

    typedef struct {
        logic          is_start;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    int n_asserts = 0;
    int n_fail    = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // N=4 instance
    logic          reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, fft_done = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] fft_addr = '0;
    logic          in_ready, mem_we, fft_start, halted;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [CW-1:0] frame_count;
    logic [2:0]    state_o;

    // N=100 instance
    logic          reset_b = 1'b1, in_valid_b = 1'b0, in_last_b = 1'b0, fft_done_b = 1'b0;
    logic [DW-1:0] in_data_b = '0;
    logic [AW-1:0] fft_addr_b = '0;
    logic          in_ready_b, mem_we_b, fft_start_b, halted_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_wdata_b;
    logic [CW-1:0] frame_count_b;
    logic [2:0]    state_o_b;

    fft_frame_controller #(.N(4), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .fft_addr(fft_addr), .fft_start(fft_start),
        .fft_done(fft_done), .frame_count(frame_count), .state_o(state_o), .halted(halted)
    );

    fft_frame_controller #(.N(100), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut_b (
        .clock(clock), .reset(reset_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_last(in_last_b), .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .fft_addr(fft_addr_b), .fft_start(fft_start_b),
        .fft_done(fft_done_b), .frame_count(frame_count_b), .state_o(state_o_b),
        .halted(halted_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_write_a(input int addr, input logic [DW-1:0] data);
        exp_t e;
        e.is_start = 1'b0; e.addr = AW'(addr); e.data = data;
        q_a.push_back(e);
    endtask

    task automatic exp_start_a();
        exp_t e;
        e.is_start = 1'b1; e.addr = '0; e.data = '0;
        q_a.push_back(e);
    endtask

    // Monitor for the N=4 instance: every write and every start pulse must be expected.
    always @(negedge clock) begin
        exp_t e;
        if (mem_we) begin
            if (q_a.size() == 0) check("unexpected_write_a", {mem_addr, mem_wdata}, '1);
            else begin
                e = q_a.pop_front();
                check("kind_write_a", 128'(e.is_start), 128'(0));
                check("addr_a", 128'(mem_addr), 128'(e.addr));
                check("wdata_a", 128'(mem_wdata), 128'(e.data));
            end
        end
        if (fft_start) begin
            if (q_a.size() == 0) check("unexpected_start_a", 128'(1), 128'(0));
            else begin
                e = q_a.pop_front();
                check("kind_start_a", 128'(e.is_start), 128'(1));
            end
        end
    end

    // Monitor for the N=100 instance.
    always @(negedge clock) begin
        exp_t e;
        if (mem_we_b) begin
            if (q_b.size() == 0) check("unexpected_write_b", {mem_addr_b, mem_wdata_b}, '1);
            else begin
                e = q_b.pop_front();
                check("kind_write_b", 128'(e.is_start), 128'(0));
                check("addr_b", 128'(mem_addr_b), 128'(e.addr));
                check("wdata_b", 128'(mem_wdata_b), 128'(e.data));
            end
        end
        if (fft_start_b) begin
            if (q_b.size() == 0) check("unexpected_start_b", 128'(1), 128'(0));
            else begin
                e = q_b.pop_front();
                check("kind_start_b", 128'(e.is_start), 128'(1));
            end
        end
    end

    // Drives four continuous samples into the N=4 instance; returns in START.
    task automatic send_frame_a(input logic [DW-1:0] base);
        for (int i = 0; i < 4; i++) exp_write_a(i, base + DW'(i));
        exp_start_a();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("start_after_4_accepts", 128'(state_o), 128'(3));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset state
        step(); step();
        check("rst_state", 128'(state_o), 128'(0));
        check("rst_outputs", {in_ready, mem_we, fft_start, halted, mem_addr}, '0);
        check("rst_frame_count", 128'(frame_count), 128'(0));
        reset = 1'b0;
        step();
        check("idle_to_load", 128'(state_o), 128'(1));
        check("load_ready", 128'(in_ready), 128'(1));

        // Full frame, then backpressure in COMPUTE
        send_frame_a(64'd1);
        step();
        check("compute_state", 128'(state_o), 128'(4));
        fft_addr = 7'd2;
        in_valid = 1'b1;
        in_data  = 64'd99;
        #1;
        check("compute_addr_mux", 128'(mem_addr), 128'(2));
        check("compute_no_ready", {in_ready, mem_we}, '0);
        step(); step();
        check("compute_hold", 128'(state_o), 128'(4));
        in_valid = 1'b0;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        check("done_to_load", 128'(state_o), 128'(1));
        check("frame_count_1", 128'(frame_count), 128'(1));

        // Stray fft_done in LOAD
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        check("stray_done_count", 128'(frame_count), 128'(1));
        check("stray_done_state", 128'(state_o), 128'(1));

        // Partial frame with zero padding
        exp_write_a(0, 64'd7); exp_write_a(1, 64'd8);
        exp_write_a(2, 64'd0); exp_write_a(3, 64'd0);
        exp_start_a();
        in_valid = 1'b1; in_data = 64'd7; step();
        in_data = 64'd8; in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        check("pad_state", 128'(state_o), 128'(2));
        step(); step();
        check("pad_to_start", 128'(state_o), 128'(3));
        step();
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        check("partial_halt_state", 128'(state_o), 128'(5));
        check("partial_halted", 128'(halted), 128'(1));
        check("partial_frame_count", 128'(frame_count), 128'(2));
        in_valid = 1'b1; in_data = 64'd55;
        #1;
        check("halt_no_ready", {in_ready, mem_we}, '0);
        step(); step();
        in_valid = 1'b0;
        check("halt_sticky", 128'(halted), 128'(1));

        // Reset, two frames (first with immediate done), then in_last alone at boundary
        reset = 1'b1;
        step();
        check("rerst_state", 128'(state_o), 128'(0));
        check("rerst_count_halt", {frame_count, halted}, '0);
        reset = 1'b0;
        step();
        send_frame_a(64'h10);
        step();
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        check("imm_done_load", 128'(state_o), 128'(1));
        check("imm_done_count", 128'(frame_count), 128'(1));
        send_frame_a(64'h20);
        step(); step();
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        check("frame2_load", 128'(state_o), 128'(1));
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        check("eof_boundary_halt", 128'(state_o), 128'(5));
        check("eof_boundary_count", 128'(frame_count), 128'(2));
        step(); step();

        // N=100: reset after 50 accepts, then a clean frame
        step();
        reset_b = 1'b0;
        step();
        check("b_load", 128'(state_o_b), 128'(1));
        for (int i = 0; i < 50; i++) begin
            exp_t e;
            e.is_start = 1'b0; e.addr = AW'(i); e.data = DW'(i + 1);
            q_b.push_back(e);
        end
        for (int i = 0; i < 50; i++) begin
            in_valid_b = 1'b1; in_data_b = DW'(i + 1);
            step();
        end
        in_valid_b = 1'b0;
        reset_b    = 1'b1;
        step();
        check("b_mid_reset_state", 128'(state_o_b), 128'(0));
        check("b_mid_reset_count", 128'(frame_count_b), 128'(0));
        reset_b = 1'b0;
        step();
        for (int i = 0; i < 100; i++) begin
            exp_t e;
            e.is_start = 1'b0; e.addr = AW'(i); e.data = DW'(1000 + i);
            q_b.push_back(e);
        end
        begin
            exp_t e;
            e.is_start = 1'b1; e.addr = '0; e.data = '0;
            q_b.push_back(e);
        end
        for (int i = 0; i < 100; i++) begin
            in_valid_b = 1'b1; in_data_b = DW'(1000 + i);
            step();
        end
        in_valid_b = 1'b0;
        check("b_start", 128'(state_o_b), 128'(3));
        step();
        fft_done_b = 1'b1;
        step();
        fft_done_b = 1'b0;
        check("b_done_load", 128'(state_o_b), 128'(1));
        check("b_frame_count", 128'(frame_count_b), 128'(1));
        step(); step();

        check("q_a_drained", 128'(q_a.size()), 128'(0));
        check("q_b_drained", 128'(q_b.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
